// File: rtl/fifo_rd_unpacker_pkg.sv
// Shared widths, types and the lane-select helper for the FIFO read unpacker.
package fifo_pkg;

    localparam int DATA_W = 128;
    localparam int OUT_W  = 32;
    localparam int BEATS  = DATA_W / OUT_W;
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [BC_W-1:0]   beat_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [OUT_W-1:0]  beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM
    } slot_state_e;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    // Beat 0 is the low lane when lsb_first is set, otherwise the high lane.
    function automatic beat_t lane_sel(word_t w, beat_idx_t idx, bit lsb_first);
        beat_idx_t lane;
        lane = lsb_first ? idx : (LAST_BEAT - idx);
        return w[int'(lane) * OUT_W +: OUT_W];
    endfunction

endpackage

// File: rtl/fifo_rd_unpacker_if.sv
// FIFO read port plus narrow output stream; master is the unpacker side.
interface fifo_rd_unpacker_if;
    import fifo_pkg::*;

    logic  i_fifo_empty;
    word_t i_fifo_rddata;
    logic  o_fifo_rden;
    logic  i_flush;
    logic  o_valid;
    beat_t o_data;
    logic  o_last;
    logic  i_ready;
    logic  o_busy;

    modport master (
        input  i_fifo_empty, i_fifo_rddata, i_flush, i_ready,
        output o_fifo_rden, o_valid, o_data, o_last, o_busy
    );

    modport slave (
        output i_fifo_empty, i_fifo_rddata, i_flush, i_ready,
        input  o_fifo_rden, o_valid, o_data, o_last, o_busy
    );

endinterface

// File: rtl/fifo_rd_unpacker_prefetch.sv
// HOLD/PF word slots with a one-deep read-in-flight flag; issues FIFO reads
// while fewer than two words are held or pending.
module fifo_rd_prefetch
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  fifo_empty_i,
    input  word_t fifo_rddata_i,
    input  logic  flush_i,
    input  logic  consume_i,
    output logic  fifo_rden_o,
    output logic  hold_valid_o,
    output word_t hold_data_o,
    output logic  busy_o
);

    slot_state_e state_q, state_d;
    word_t       hold_q, hold_d;
    word_t       pf_q, pf_d;
    logic        pf_valid_q, pf_valid_d;
    logic        inf_q, inf_d;
    logic        hold_valid, hold_valid_d;
    logic        capture;
    logic [1:0]  credit;

    assign hold_valid = (state_q == ST_STREAM);
    assign credit     = {1'b0, hold_valid} + {1'b0, pf_valid_q} + {1'b0, inf_q};
    assign capture    = inf_q && !flush_i;

    // rstn gates the enable so no read escapes while reset is held.
    assign fifo_rden_o  = rstn && !fifo_empty_i && (credit < 2'd2) && !flush_i;
    assign hold_valid_o = hold_valid;
    assign hold_data_o  = hold_q;
    assign busy_o       = hold_valid || pf_valid_q || inf_q;

    always_comb begin
        hold_d       = hold_q;
        pf_d         = pf_q;
        pf_valid_d   = pf_valid_q;
        hold_valid_d = hold_valid;
        inf_d        = fifo_rden_o;
        if (flush_i) begin
            hold_valid_d = 1'b0;
            pf_valid_d   = 1'b0;
        end else if (consume_i) begin
            // On the last-beat accept PF moves up first, so a concurrent capture lands in PF with no bubble.
            if (pf_valid_q) begin
                hold_d       = pf_q;
                hold_valid_d = 1'b1;
                pf_valid_d   = capture;
                if (capture) pf_d = fifo_rddata_i;
            end else if (capture) begin
                hold_d       = fifo_rddata_i;
                hold_valid_d = 1'b1;
            end else begin
                hold_valid_d = 1'b0;
            end
        end else if (capture) begin
            if (!hold_valid) begin
                hold_d       = fifo_rddata_i;
                hold_valid_d = 1'b1;
            end else begin
                pf_d       = fifo_rddata_i;
                pf_valid_d = 1'b1;
            end
        end
        state_d = hold_valid_d ? ST_STREAM : (inf_d ? ST_WAIT : ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
            inf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pf_q       <= pf_d;
            pf_valid_q <= pf_valid_d;
            inf_q      <= inf_d;
        end
    end

endmodule

// File: rtl/fifo_rd_unpacker.sv
// Drains a wide FIFO and re-emits each word as BEATS narrow valid/ready beats.
module fifo_rd_unpacker
    import fifo_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rstn,
    fifo_rd_unpacker_if.master bus
);

    beat_idx_t bc_q, bc_d;
    logic      hold_valid;
    word_t     hold_data;
    logic      accept;
    logic      consume;

    fifo_rd_prefetch u_prefetch (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_empty_i (bus.i_fifo_empty),
        .fifo_rddata_i(bus.i_fifo_rddata),
        .flush_i      (bus.i_flush),
        .consume_i    (consume),
        .fifo_rden_o  (bus.o_fifo_rden),
        .hold_valid_o (hold_valid),
        .hold_data_o  (hold_data),
        .busy_o       (bus.o_busy)
    );

    assign accept  = hold_valid && bus.i_ready;
    assign consume = accept && (bc_q == LAST_BEAT);

    assign bus.o_valid = hold_valid;
    assign bus.o_data  = lane_sel(hold_data, bc_q, LSB_FIRST);
    assign bus.o_last  = (bc_q == LAST_BEAT);

    always_comb begin
        bc_d = bc_q;
        if (bus.i_flush || consume) begin
            bc_d = '0;
        end else if (accept) begin
            bc_d = bc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bc_q <= '0;
        end else begin
            bc_q <= bc_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Directed bench: a FIFO model feeds two unpackers (LSB-first and MSB-first);
// a scoreboard of expected beats is filled on push and drained on accept.
module tb_fifo_rd_unpacker;
    import fifo_pkg::*;

    typedef logic [127:0] chk_t;

    typedef struct packed {
        logic [OUT_W-1:0] lsbData;
        logic [OUT_W-1:0] msbData;
        logic             last;
    } expBeat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    fifo_rd_unpacker_if busLsb ();
    fifo_rd_unpacker_if busMsb ();

    fifo_rd_unpacker #(.LSB_FIRST(1'b1)) dutLsb (.clk(clk), .rstn(rstn), .bus(busLsb));
    fifo_rd_unpacker #(.LSB_FIRST(1'b0)) dutMsb (.clk(clk), .rstn(rstn), .bus(busMsb));

    always #5 clk = ~clk;

    word_t            fifoQ[$];
    expBeat_t         expQ[$];
    int               checkCount = 0;
    int               failCount = 0;
    int               rdenCount = 0;
    int               acceptCount = 0;
    int               cycleCount = 0;
    int               lastAcceptCycle = 0;
    logic             rdenSeen = 1'b0;
    logic             stallPending = 1'b0;
    logic [OUT_W-1:0] stallData = '0;

    task automatic checkOutput(input string tag, input chk_t observed, input chk_t expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic flush);
        busLsb.i_ready = ready;
        busMsb.i_ready = ready;
        busLsb.i_flush = flush;
        busMsb.i_flush = flush;
    endtask

    task automatic setFifoOutputs(input word_t data);
        busLsb.i_fifo_rddata = data;
        busMsb.i_fifo_rddata = data;
        busLsb.i_fifo_empty  = (fifoQ.size() == 0);
        busMsb.i_fifo_empty  = (fifoQ.size() == 0);
    endtask

    task automatic expectWord(input word_t w);
        for (int b = 0; b < BEATS; b++) begin
            expBeat_t e;
            e.lsbData = w[b*OUT_W +: OUT_W];
            e.msbData = w[(BEATS-1-b)*OUT_W +: OUT_W];
            e.last    = (b == BEATS - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic pushWord(input word_t w);
        fifoQ.push_back(w);
        expectWord(w);
        setFifoOutputs(busLsb.i_fifo_rddata);
    endtask

    // Called on the falling edge, midway between active edges.
    task automatic sampleCycle();
        expBeat_t e;
        rdenSeen = busLsb.o_fifo_rden;
        if (rdenSeen) begin
            rdenCount++;
            checkOutput("rdenWhileEmpty", chk_t'(busLsb.i_fifo_empty), chk_t'(0));
        end
        if (stallPending) begin
            checkOutput("stallValid", chk_t'(busLsb.o_valid), chk_t'(1));
            checkOutput("stallData", chk_t'(busLsb.o_data), chk_t'(stallData));
        end
        if (busLsb.o_valid && busLsb.i_ready) begin
            acceptCount++;
            lastAcceptCycle = cycleCount;
            checkOutput("beatExpected", chk_t'(expQ.size() != 0), chk_t'(1));
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("lsbData", chk_t'(busLsb.o_data), chk_t'(e.lsbData));
                checkOutput("lsbLast", chk_t'(busLsb.o_last), chk_t'(e.last));
                checkOutput("msbValid", chk_t'(busMsb.o_valid), chk_t'(1));
                checkOutput("msbData", chk_t'(busMsb.o_data), chk_t'(e.msbData));
                checkOutput("msbLast", chk_t'(busMsb.o_last), chk_t'(e.last));
            end
        end
        stallPending = busLsb.o_valid && !busLsb.i_ready;
        stallData    = busLsb.o_data;
    endtask

    // One cycle: check at negedge, then model the FIFO read port just after posedge.
    task automatic stepCycle();
        word_t d;
        @(negedge clk);
        sampleCycle();
        @(posedge clk);
        #1;
        cycleCount++;
        d = busLsb.i_fifo_rddata;
        if (rdenSeen && fifoQ.size() != 0) d = fifoQ.pop_front();
        setFifoOutputs(d);
    endtask

    task automatic waitAccepts(input int target, input int budget);
        int n = 0;
        while (acceptCount < target && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("acceptTimeout", chk_t'(acceptCount >= target), chk_t'(1));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((expQ.size() != 0 || busLsb.o_busy) && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "Remaining"}, chk_t'(expQ.size()), chk_t'(0));
        checkOutput({tag, "Busy"}, chk_t'(busLsb.o_busy), chk_t'(0));
    endtask

    initial begin
        int c;
        int rd0;
        int base;
        int t0;
        logic readyNow;
        word_t w;

        applyStimulus(1'b0, 1'b0);
        setFifoOutputs('0);
        #1;
        checkOutput("resetRden", chk_t'(busLsb.o_fifo_rden), chk_t'(0));
        checkOutput("resetValid", chk_t'(busLsb.o_valid), chk_t'(0));
        checkOutput("resetData", chk_t'(busLsb.o_data), chk_t'(0));
        checkOutput("resetLast", chk_t'(busLsb.o_last), chk_t'(0));
        checkOutput("resetBusy", chk_t'(busLsb.o_busy), chk_t'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        stepCycle();

        $display("[TB] single word, latency and lane order");
        applyStimulus(1'b1, 1'b0);
        c    = cycleCount;
        rd0  = rdenCount;
        base = acceptCount;
        pushWord(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        waitAccepts(base + 1, 10);
        checkOutput("firstBeatCycle", chk_t'(lastAcceptCycle - c), chk_t'(2));
        drain("single", 20);
        checkOutput("lastBeatCycle", chk_t'(lastAcceptCycle - c), chk_t'(5));
        checkOutput("singleRden", chk_t'(rdenCount - rd0), chk_t'(1));

        $display("[TB] eight words back-to-back");
        rd0  = rdenCount;
        base = acceptCount;
        for (int i = 0; i < 8; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            pushWord(w);
        end
        waitAccepts(base + 1, 10);
        t0 = lastAcceptCycle;
        drain("burst", 100);
        checkOutput("burstSpan", chk_t'(lastAcceptCycle - t0), chk_t'(31));
        checkOutput("burstRden", chk_t'(rdenCount - rd0), chk_t'(8));

        $display("[TB] ready toggling across three words");
        rd0 = rdenCount;
        readyNow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            pushWord(w);
        end
        for (int n = 0; n < 200 && (expQ.size() != 0 || busLsb.o_busy); n++) begin
            readyNow = ~readyNow;
            applyStimulus(readyNow, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b1, 1'b0);
        drain("stall", 20);
        checkOutput("stallRden", chk_t'(rdenCount - rd0), chk_t'(3));

        $display("[TB] flush with beat 2 pending and a read in flight");
        rd0  = rdenCount;
        base = acceptCount;
        pushWord(128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0);
        waitAccepts(base + 2, 20);
        applyStimulus(1'b0, 1'b0);
        pushWord(128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0);
        stepCycle();
        checkOutput("flushReadIssued", chk_t'(rdenCount - rd0), chk_t'(2));
        applyStimulus(1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        expQ.delete();
        stallPending = 1'b0;
        checkOutput("flushValid", chk_t'(busLsb.o_valid), chk_t'(0));
        checkOutput("flushBusy", chk_t'(busLsb.o_busy), chk_t'(0));
        pushWord(128'hC3C3_C3C3_C2C2_C2C2_C1C1_C1C1_C0C0_C0C0);
        drain("flush", 30);
        checkOutput("flushRden", chk_t'(rdenCount - rd0), chk_t'(3));

        $display("[TB] asynchronous reset mid-word");
        base = acceptCount;
        for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            pushWord(w);
        end
        waitAccepts(base + 5, 30);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("midResetRden", chk_t'(busLsb.o_fifo_rden), chk_t'(0));
        checkOutput("midResetValid", chk_t'(busLsb.o_valid), chk_t'(0));
        checkOutput("midResetData", chk_t'(busLsb.o_data), chk_t'(0));
        checkOutput("midResetLast", chk_t'(busLsb.o_last), chk_t'(0));
        checkOutput("midResetBusy", chk_t'(busLsb.o_busy), chk_t'(0));
        expQ.delete();
        foreach (fifoQ[i]) expectWord(fifoQ[i]);
        stallPending = 1'b0;
        repeat (2) stepCycle();
        #1;
        rstn = 1'b1;
        #1;
        checkOutput("rdenAfterReset", chk_t'(busLsb.o_fifo_rden), chk_t'(1));
        drain("reset", 100);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
